fetch_decode_fsm: RTL and testbench
===================================

FETCH_DECODE_FSM -- requirements
Module: fetch_decode_fsm

Interface
REQ-001 SHALL have parameter PC_W, default 8, program-counter and address width.
REQ-002 SHALL have parameter TIMEOUT, default 8'd200, max EXEC_WAIT cycles before error.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mfc  input  1  memory-function-complete; memData valid when high.
REQ-006 SHALL have port memData  input  16  instruction word {opcode[15:12], para1[11:6], para2[5:0]}.
REQ-007 SHALL have port resVec  input  7  done pulses from sub-FSMs, bit order equal to the nextFSM one-hot encoding.
REQ-008 SHALL have port memRead  output  1  instruction read request.
REQ-009 SHALL have port memAddr  output  PC_W  read address, equal to the PC.
REQ-010 SHALL have port nextFSM  output  7  one-hot sub-FSM select: AluPar2 0000001, AluPar1 0000010, AluNot 0000100, Move 0001000, Movi 0010000, Load 0100000, Store 1000000, Error 1111111, Blank 0000000.
REQ-011 SHALL have port para1 and para2  output  6 each  registered operand fields of the current instruction.
REQ-012 SHALL have port err  output  1  sticky error flag.

Function
REQ-013 SHALL implement states FETCH_REQ, FETCH_WAIT, DECODE, DISPATCH, EXEC_WAIT, ERROR.
REQ-014 FETCH_REQ SHALL assert memRead with memAddr=PC for 1 cycle, then go to FETCH_WAIT.
REQ-015 FETCH_WAIT SHALL hold memRead high; when mfc=1, IR<=memData, memRead drops next cycle, go to DECODE; mfc SHALL be ignored in all other states.
REQ-016 DECODE SHALL map opcode: 0001-0110 -> AluPar2; 1000,1001 -> AluPar1; 0111 -> AluNot; 1010 -> Move; 1011 -> Movi; 1100 -> Load; 1101 -> Store; 0000,1110,1111 -> ERROR; para1/para2 SHALL update from IR in this cycle.
REQ-017 DISPATCH SHALL drive nextFSM to the decoded one-hot code for exactly 1 cycle, then Blank; SHALL clear timeout counter and go to EXEC_WAIT.
REQ-018 EXEC_WAIT SHALL wait for resVec bit matching the dispatched code; other bits SHALL be ignored; on match PC<=PC+1 (wraps 2^PC_W-1 -> 0) and go to FETCH_REQ.
REQ-019 A matching resVec bit arriving in the DISPATCH cycle SHALL be ignored (sub-FSM cannot finish in 0 cycles).
REQ-020 EXEC_WAIT SHALL increment an 8-bit counter per cycle; counter reaching TIMEOUT without match SHALL go to ERROR.
REQ-021 ERROR SHALL drive nextFSM=Error, err=1, memRead=0, and hold until rst.
REQ-022 Minimum instruction latency SHALL be 5 cycles plus mfc wait plus sub-FSM latency; no overlap of fetch and execute.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 rst=1 at any clock edge SHALL set state=FETCH_REQ, PC=0, IR=0, counter=0, memRead=0, memAddr=0, nextFSM=Blank, para1=para2=0, err=0, regardless of state (mid-fetch or mid-execute).
REQ-025 First memRead SHALL assert in the first cycle after rst deasserts.

Structure
REQ-026 Opcode constants (4-bit), nextFSM one-hot codes (7-bit), and state encodings SHALL live in a shared package used by all sub-FSMs.
REQ-027 Opcode-to-one-hot mapping SHALL be a combinational sub-module op_decode (in 4, out 7, Error code for illegal).

Verification
REQ-028 Reset, memData=16'hB002 (Movi, para2=2), mfc after 3 cycles -> memAddr=0, nextFSM=0010000 one cycle, para2=6'd2; resVec=0010000 pulse -> PC=1, memRead re-asserts.
REQ-029 Opcode 0011 (And) dispatched, resVec=0010000 then 0000001 -> first pulse ignored, PC increments only after second.
REQ-030 memData=16'h0000 -> ERROR, nextFSM=1111111, err=1, no further memRead until rst.
REQ-031 Dispatch Load, no resVec for 200 cycles -> ERROR with err=1.
REQ-032 PC=255, Store completes -> PC=0, memAddr=0 on next fetch.
REQ-033 rst asserted during FETCH_WAIT and during EXEC_WAIT -> all outputs at reset values next cycle, fetch restarts at address 0.

Source files
------------

// File: rtl/fetch_decode_fsm_pkg.sv
// Shared constants for the fetch/decode controller and its sub-FSMs.
// Contents: 4-bit opcodes, 7-bit one-hot sub-FSM select codes, and the
// controller state encoding.
package fetch_decode_fsm_pkg;

  // Opcodes. The range 0x1..0x6 is the two-operand ALU group.
  localparam logic [3:0] OP_ALU2_FIRST = 4'h1;
  localparam logic [3:0] OP_ALU2_LAST  = 4'h6;
  localparam logic [3:0] OP_NOT        = 4'h7;
  localparam logic [3:0] OP_ALU1_A     = 4'h8;
  localparam logic [3:0] OP_ALU1_B     = 4'h9;
  localparam logic [3:0] OP_MOVE       = 4'hA;
  localparam logic [3:0] OP_MOVI       = 4'hB;
  localparam logic [3:0] OP_LOAD       = 4'hC;
  localparam logic [3:0] OP_STORE      = 4'hD;

  // One-hot sub-FSM select codes; resVec uses the same bit order.
  localparam logic [6:0] NF_BLANK   = 7'b0000000;
  localparam logic [6:0] NF_ALUPAR2 = 7'b0000001;
  localparam logic [6:0] NF_ALUPAR1 = 7'b0000010;
  localparam logic [6:0] NF_ALUNOT  = 7'b0000100;
  localparam logic [6:0] NF_MOVE    = 7'b0001000;
  localparam logic [6:0] NF_MOVI    = 7'b0010000;
  localparam logic [6:0] NF_LOAD    = 7'b0100000;
  localparam logic [6:0] NF_STORE   = 7'b1000000;
  localparam logic [6:0] NF_ERROR   = 7'b1111111;

  typedef enum logic [2:0] {
    S_FETCH_REQ  = 3'd0,
    S_FETCH_WAIT = 3'd1,
    S_DECODE     = 3'd2,
    S_DISPATCH   = 3'd3,
    S_EXEC_WAIT  = 3'd4,
    S_ERROR      = 3'd5
  } state_e;

endpackage

// File: rtl/fetch_decode_fsm_if.sv
// Memory/sub-FSM bundle of the fetch/decode controller.
//   mfc, memData   : memory completion and returned instruction word
//   resVec         : done pulses from the sub-FSMs (one-hot order)
//   memRead/memAddr: instruction read request and address (= PC)
//   nextFSM        : one-hot sub-FSM select
//   para1/para2    : operand fields of the current instruction
//   err            : sticky error flag
// master = controller side, slave = memory/sub-FSM side.
interface fetch_decode_fsm_if #(
  parameter int unsigned PC_W = 8
);
  logic            mfc;
  logic [15:0]     memData;
  logic [6:0]      resVec;
  logic            memRead;
  logic [PC_W-1:0] memAddr;
  logic [6:0]      nextFSM;
  logic [5:0]      para1;
  logic [5:0]      para2;
  logic            err;

  modport master (
    input  mfc, memData, resVec,
    output memRead, memAddr, nextFSM, para1, para2, err
  );

  modport slave (
    output mfc, memData, resVec,
    input  memRead, memAddr, nextFSM, para1, para2, err
  );
endinterface

// File: rtl/fetch_decode_fsm_op_decode.sv
// Combinational opcode decoder: 4-bit opcode to 7-bit one-hot sub-FSM code.
//   op_i   : opcode field of the instruction register
//   code_o : one-hot select, NF_ERROR for illegal opcodes (0x0, 0xE, 0xF)
module op_decode
  import fetch_decode_fsm_pkg::*;
(
  input  logic [3:0] op_i,
  output logic [6:0] code_o
);

  always_comb begin
    code_o = NF_ERROR;
    if (op_i inside {[OP_ALU2_FIRST:OP_ALU2_LAST]}) begin
      code_o = NF_ALUPAR2;
    end else begin
      case (op_i)
        OP_NOT:               code_o = NF_ALUNOT;
        OP_ALU1_A, OP_ALU1_B: code_o = NF_ALUPAR1;
        OP_MOVE:              code_o = NF_MOVE;
        OP_MOVI:              code_o = NF_MOVI;
        OP_LOAD:              code_o = NF_LOAD;
        OP_STORE:             code_o = NF_STORE;
        default:              code_o = NF_ERROR;
      endcase
    end
  end

endmodule

// File: rtl/fetch_decode_fsm.sv
// Instruction fetch/decode/dispatch controller.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : master side of fetch_decode_fsm_if (memory read, sub-FSM select,
//         operand fields, done pulses, sticky error)
// One instruction at a time: fetch, decode, dispatch a one-hot select for
// one cycle, then wait for the matching done bit or a timeout.
module fetch_decode_fsm
  import fetch_decode_fsm_pkg::*;
#(
  parameter int unsigned PC_W    = 8,
  parameter logic [7:0]  TIMEOUT = 8'd200
) (
  input  logic               clk,
  input  logic               rst,
  fetch_decode_fsm_if.master bus
);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            memread_q, memread_d;
  logic [6:0]      nextfsm_q, nextfsm_d;
  logic [6:0]      code_q, code_d;
  logic [5:0]      para1_q, para1_d;
  logic [5:0]      para2_q, para2_d;
  logic            err_q, err_d;
  logic [6:0]      dec_code;
  logic [7:0]      cnt_inc;

  op_decode u_op_decode (
    .op_i   (ir_q[15:12]),
    .code_o (dec_code)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    memread_d = memread_q;
    nextfsm_d = NF_BLANK;
    code_d    = code_q;
    para1_d   = para1_q;
    para2_d   = para2_q;
    err_d     = err_q;
    cnt_inc   = cnt_q + 8'd1;

    unique case (state_q)
      S_FETCH_REQ: begin
        memread_d = 1'b1;
        state_d   = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        if (bus.mfc) begin
          ir_d      = bus.memData;
          memread_d = 1'b0;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        para1_d = ir_q[11:6];
        para2_d = ir_q[5:0];
        code_d  = dec_code;
        if (dec_code == NF_ERROR) begin
          nextfsm_d = NF_ERROR;
          err_d     = 1'b1;
          state_d   = S_ERROR;
        end else begin
          state_d = S_DISPATCH;
        end
      end
      S_DISPATCH: begin
        // resVec is not looked at here: a sub-FSM cannot finish in 0 cycles.
        nextfsm_d = code_q;
        cnt_d     = '0;
        state_d   = S_EXEC_WAIT;
      end
      S_EXEC_WAIT: begin
        if ((bus.resVec & code_q) != '0) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_FETCH_REQ;
        end else if (cnt_inc == TIMEOUT) begin
          nextfsm_d = NF_ERROR;
          err_d     = 1'b1;
          state_d   = S_ERROR;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_ERROR: begin
        nextfsm_d = NF_ERROR;
        err_d     = 1'b1;
        memread_d = 1'b0;
      end
      default: state_d = S_FETCH_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH_REQ;
      pc_q      <= '0;
      ir_q      <= '0;
      cnt_q     <= '0;
      memread_q <= 1'b0;
      nextfsm_q <= NF_BLANK;
      code_q    <= NF_BLANK;
      para1_q   <= '0;
      para2_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      memread_q <= memread_d;
      nextfsm_q <= nextfsm_d;
      code_q    <= code_d;
      para1_q   <= para1_d;
      para2_q   <= para2_d;
      err_q     <= err_d;
    end
  end

  // The PC register doubles as the read address.
  assign bus.memAddr = pc_q;
  assign bus.memRead = memread_q;
  assign bus.nextFSM = nextfsm_q;
  assign bus.para1   = para1_q;
  assign bus.para2   = para2_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_fetch_decode_fsm.sv
// Self-checking bench for fetch_decode_fsm: a cycle reference model of the
// fetch/decode/dispatch rules, compared every cycle, plus literal checks.
module tb_fetch_decode_fsm;
  localparam int unsigned PC_W = 8;
  localparam int          TMO  = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_decode_fsm_if #(.PC_W(PC_W)) bus ();

  fetch_decode_fsm #(
    .PC_W    (PC_W),
    .TIMEOUT (8'(TMO))
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Opcode -> one-hot select, straight from the opcode table.
  function automatic logic [6:0] ref_code(input int op);
    if (op >= 1 && op <= 6) return 7'b0000001;
    if (op == 8 || op == 9) return 7'b0000010;
    if (op == 7)            return 7'b0000100;
    if (op == 10)           return 7'b0001000;
    if (op == 11)           return 7'b0010000;
    if (op == 12)           return 7'b0100000;
    if (op == 13)           return 7'b1000000;
    return 7'b1111111;
  endfunction

  // ---------------- reference model ----------------
  localparam int M_FETCH = 0, M_MEMWAIT = 1, M_DECODE = 2, M_DISPATCH = 3,
                 M_EXEC = 4, M_HALT = 5;
  bit          m_live = 1'b0;
  int          m_stage, m_pc, m_wait;
  logic [15:0] m_ir;
  logic [6:0]  m_code;
  bit          e_read, e_err;
  logic [6:0]  e_next;
  logic [5:0]  e_p1, e_p2;

  task automatic model_step();
    if (rst) begin
      m_live = 1'b1; m_stage = M_FETCH; m_pc = 0; m_wait = 0; m_ir = '0;
      m_code = '0; e_read = 1'b0; e_err = 1'b0; e_next = '0; e_p1 = '0; e_p2 = '0;
    end else if (m_live) begin
      if (m_stage != M_HALT) e_next = '0;
      case (m_stage)
        M_FETCH: begin e_read = 1'b1; m_stage = M_MEMWAIT; end
        M_MEMWAIT: if (bus.mfc) begin
          m_ir = bus.memData; e_read = 1'b0; m_stage = M_DECODE;
        end
        M_DECODE: begin
          e_p1 = m_ir[11:6]; e_p2 = m_ir[5:0];
          m_code = ref_code(int'(m_ir[15:12]));
          if (m_code == 7'h7F) begin e_next = 7'h7F; e_err = 1'b1; m_stage = M_HALT; end
          else m_stage = M_DISPATCH;
        end
        M_DISPATCH: begin e_next = m_code; m_wait = 0; m_stage = M_EXEC; end
        M_EXEC: begin
          if ((bus.resVec & m_code) != 7'd0) begin
            m_pc = (m_pc + 1) % (1 << PC_W); m_stage = M_FETCH;
          end else begin
            m_wait++;
            if (m_wait == TMO) begin e_next = 7'h7F; e_err = 1'b1; m_stage = M_HALT; end
          end
        end
        default: ;
      endcase
    end
  endtask

  initial forever begin @(posedge clk); model_step(); end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (m_live) begin
      check("memRead", 32'(bus.memRead), 32'(e_read));
      check("memAddr", 32'(bus.memAddr), 32'(m_pc));
      check("nextFSM", 32'(bus.nextFSM), 32'(e_next));
      check("para1",   32'(bus.para1),   32'(e_p1));
      check("para2",   32'(bus.para2),   32'(e_p2));
      check("err",     32'(bus.err),     32'(e_err));
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  logic [6:0] obs_nf0, obs_nf1;
  logic [5:0] obs_p1, obs_p2;
  logic [7:0] obs_addr_fetch, obs_addr_mid, obs_addr_end;
  logic       obs_read;

  task automatic run_instr(input logic [15:0] word, input int mfc_wait, input int exec_lat,
                           input bit glitch, input logic [6:0] early, input bit respond,
                           input int abort_at, input bit noise);
    logic [6:0] code;
    int n;
    code = ref_code(int'(word[15:12]));
    n = 0;
    while (!bus.memRead && n < 20) begin
      bus.mfc = 1'b0; @(negedge clk); n++;
    end
    check("fetch_start_bound", 32'(bus.memRead), 32'd1);
    obs_addr_fetch = 8'(bus.memAddr);
    repeat (mfc_wait) begin
      bus.mfc = 1'b0; bus.memData = 16'($urandom);
      bus.resVec = noise ? 7'($urandom) : 7'd0;
      @(negedge clk);
    end
    bus.mfc = 1'b1; bus.memData = word; bus.resVec = noise ? 7'($urandom) : 7'd0;
    @(negedge clk);
    bus.mfc = 1'($urandom); bus.memData = 16'($urandom);
    bus.resVec = noise ? 7'($urandom) : 7'd0;
    @(negedge clk);
    if (code == 7'h7F) begin bus.mfc = 1'b0; bus.resVec = '0; return; end
    bus.resVec = (noise ? 7'($urandom) : 7'd0) | (glitch ? code : 7'd0);
    @(negedge clk);
    obs_nf0 = bus.nextFSM; obs_p1 = bus.para1; obs_p2 = bus.para2;
    for (int k = 0; k < TMO + 4; k++) begin
      bus.mfc = noise ? 1'($urandom) : 1'b0; bus.memData = 16'($urandom);
      bus.resVec = (noise ? (7'($urandom) & ~code) : 7'd0) | (k == 0 ? early : 7'd0)
                 | ((respond && k == exec_lat) ? code : 7'd0);
      if (k == abort_at) begin
        rst = 1'b1; @(negedge clk); bus.resVec = '0; return;
      end
      @(negedge clk);
      if (k == 0) begin obs_nf1 = bus.nextFSM; obs_addr_mid = 8'(bus.memAddr); end
      if (respond && k == exec_lat) break;
    end
    obs_addr_end = 8'(bus.memAddr);
    bus.mfc = 1'($urandom); bus.resVec = '0;
    @(negedge clk);
    obs_read = bus.memRead;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_memRead"}, 32'(bus.memRead), 32'd0);
    check({tag, "_memAddr"}, 32'(bus.memAddr), 32'd0);
    check({tag, "_nextFSM"}, 32'(bus.nextFSM), 32'd0);
    check({tag, "_para1"},   32'(bus.para1),   32'd0);
    check({tag, "_para2"},   32'(bus.para2),   32'd0);
    check({tag, "_err"},     32'(bus.err),     32'd0);
  endtask

  initial begin
    bus.mfc = 1'b0; bus.memData = '0; bus.resVec = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check("first_read", 32'(bus.memRead), 32'd1);

    // Movi, para2 = 2, mfc after 3 cycles, done pulse right away.
    run_instr(16'hB002, 3, 0, 1'b0, 7'd0, 1'b1, -1, 1'b0);
    check("movi_addr",  32'(obs_addr_fetch), 32'd0);
    check("movi_next",  32'(obs_nf0), 32'b0010000);
    check("movi_blank", 32'(obs_nf1), 32'd0);
    check("movi_para2", 32'(obs_p2),  32'd2);
    check("movi_para1", 32'(obs_p1),  32'd0);
    check("movi_pc",    32'(obs_addr_end), 32'd1);
    check("movi_reread", 32'(obs_read), 32'd1);

    // And: wrong done bit first, then the matching one.
    run_instr(16'h3A5C, 1, 2, 1'b0, 7'b0010000, 1'b1, -1, 1'b0);
    check("and_next",    32'(obs_nf0), 32'b0000001);
    check("and_para1",   32'(obs_p1),  32'h29);
    check("and_pc_hold", 32'(obs_addr_mid), 32'd1);
    check("and_pc_inc",  32'(obs_addr_end), 32'd2);

    // Reset in EXEC_WAIT.
    run_instr(16'hA123, 1, 5, 1'b1, 7'd0, 1'b1, 2, 1'b1);
    check_reset_outputs("rst_exec");
    rst = 1'b0;
    @(negedge clk);
    check("rst_exec_read", 32'(bus.memRead), 32'd1);
    check("rst_exec_addr", 32'(bus.memAddr), 32'd0);

    // Reset in FETCH_WAIT with a nonzero PC.
    run_instr(16'h7FFF, 0, 1, 1'b1, 7'd0, 1'b1, -1, 1'b1);
    check("pre_rst_fetch_addr", 32'(bus.memAddr), 32'd1);
    bus.mfc = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_fetch");
    rst = 1'b0;
    @(negedge clk);
    check("rst_fetch_read", 32'(bus.memRead), 32'd1);
    check("rst_fetch_addr", 32'(bus.memAddr), 32'd0);

    // Random legal instructions up to PC = 255.
    for (int i = 0; i < 255; i++) begin
      run_instr({4'($urandom_range(1, 13)), 12'($urandom)}, $urandom_range(0, 3),
                $urandom_range(0, 4), 1'($urandom), 7'd0, 1'b1, -1, 1'b1);
    end
    check("pc_255", 32'(bus.memAddr), 32'd255);
    run_instr({4'hD, 12'($urandom)}, 1, 1, 1'b1, 7'd0, 1'b1, -1, 1'b1);
    check("store_next", 32'(obs_nf0), 32'b1000000);
    check("pc_wrap",    32'(obs_addr_end), 32'd0);
    check("wrap_read",  32'(obs_read), 32'd1);

    // Load never completes: timeout.
    run_instr({4'hC, 12'($urandom)}, 1, 0, 1'b1, 7'd0, 1'b0, -1, 1'b1);
    check("tmo_err",  32'(bus.err), 32'd1);
    check("tmo_next", 32'(bus.nextFSM), 32'h7F);
    check("tmo_read", 32'(bus.memRead), 32'd0);

    // Illegal opcodes halt until reset.
    for (int j = 0; j < 2; j++) begin
      rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
      run_instr(j == 0 ? 16'h0000 : 16'hE3C1, 0, 0, 1'b0, 7'd0, 1'b1, -1, 1'b1);
      check("ill_err",  32'(bus.err), 32'd1);
      check("ill_next", 32'(bus.nextFSM), 32'h7F);
      repeat (10) begin
        bus.mfc = 1'($urandom); bus.memData = 16'($urandom); bus.resVec = 7'($urandom);
        @(negedge clk);
        check("ill_no_read", 32'(bus.memRead), 32'd0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
